// File: rtl/spi_port.sv
// Z180 I/O-mapped SPI master: data register at BASE_ADDR, control/status at BASE_ADDR+1.
// Serialises one byte per data write, MSB first, SPI mode 0.
//
// state   | meaning
// S_IDLE  | no transfer, sck low, busy low
// S_LOAD  | one cycle: copy tx into shift register, present bit 7
// S_SHIFT | toggling sck every div+1 cycles until the 8th falling edge
module spi_port #(
  parameter logic [7:0] BASE_ADDR = 8'h80
) (
  input  logic       PHI,
  input  logic       reset,
  input  logic [7:0] A,
  input  logic [7:0] D,
  input  logic       IORQ,
  input  logic       RD,
  input  logic       WR,
  input  logic       M1,
  output logic [7:0] data_out,
  output logic       data_en,
  output logic       waiting,
  output logic       spi_sdo,
  output logic       spi_sck,
  input  logic       spi_sdi,
  output logic [1:0] spi_select
);

  localparam logic [7:0] CTRL_ADDR = BASE_ADDR + 8'd1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic        samp_q, samp_d;
  logic        sdo_q, sdo_d;
  logic        sck_q, sck_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  hp_q, hp_d;
  logic [1:0]  div_q, div_d;
  logic [1:0]  sel_q, sel_d;
  logic        done_q, done_d;

  logic        is_data, is_ctrl, acc, busy, act;

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    shift_d = shift_q;
    rx_d    = rx_q;
    samp_d  = samp_q;
    sdo_d   = sdo_q;
    sck_d   = sck_q;
    bit_d   = bit_q;
    hp_d    = hp_q;
    div_d   = div_q;
    sel_d   = sel_q;

    is_data = (A == BASE_ADDR);
    is_ctrl = (A == CTRL_ADDR);
    acc     = ~IORQ & M1 & (~RD | ~WR) & (is_data | is_ctrl);
    busy    = (state_q != S_IDLE);
    waiting = acc & is_data & busy & ~done_q;
    // An access is taken once; data-register accesses hold off until the shifter is free.
    act     = acc & ~done_q & ~(is_data & busy);
    done_d  = acc & (done_q | act);

    data_en  = ~RD & ~IORQ & M1 & (is_data | is_ctrl);
    data_out = is_ctrl ? {busy, 1'b0, div_q, 2'b00, sel_q} : rx_q;

    case (state_q)
      S_IDLE: ;
      S_LOAD: begin
        shift_d = tx_q;
        sdo_d   = tx_q[7];
        sck_d   = 1'b0;
        bit_d   = 3'd0;
        hp_d    = div_q;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (hp_q != 2'd0) begin
          hp_d = hp_q - 2'd1;
        end else begin
          hp_d  = div_q;
          sck_d = ~sck_q;
          if (!sck_q) begin
            samp_d = spi_sdi;
          end else begin
            shift_d = {shift_q[6:0], samp_q};
            sdo_d   = shift_q[6];
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              rx_d    = {shift_q[6:0], samp_q};
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (act && !WR) begin
      if (is_data) begin
        tx_d    = D;
        state_d = S_LOAD;
      end else begin
        sel_d = D[1:0];
        div_d = D[5:4];
      end
    end
  end

  always_ff @(posedge PHI or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tx_q    <= 8'h00;
      shift_q <= 8'h00;
      rx_q    <= 8'hFF;
      samp_q  <= 1'b0;
      sdo_q   <= 1'b1;
      sck_q   <= 1'b0;
      bit_q   <= 3'd0;
      hp_q    <= 2'd0;
      div_q   <= 2'b11;
      sel_q   <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      samp_q  <= samp_d;
      sdo_q   <= sdo_d;
      sck_q   <= sck_d;
      bit_q   <= bit_d;
      hp_q    <= hp_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  assign spi_sdo    = sdo_q;
  assign spi_sck    = sck_q;
  assign spi_select = sel_q;

endmodule
